regfile_write_arbiter: RTL

//   Shares the register file's single write port between the ALU result path and the memory-load path.
//   - Round-robin arbitration between the two requesters.
//   - Registers the winning write onto wr_enable/wr_addr/wr_data.
//   - Keeps a 16-entry pending-write scoreboard and flags read-after-write hazards.

---
 rtl/regfile_write_arbiter.sv | 103 ++++++++++
 1 files changed

// File: rtl/regfile_write_arbiter.sv
// Round-robin write-port arbiter (ALU vs load) with a pending-write scoreboard and RAW hazard flag.
// Defining REGFILE_ARB_STATS_EN adds a saturating conflict_count output.
package constants_pkg;
    localparam int unsigned REGISTER_DATA_BITS = 8;
endpackage

module regfile_write_arbiter #(
    parameter int unsigned DATA_BITS = constants_pkg::REGISTER_DATA_BITS
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 claim_valid,
    input  logic [3:0]           claim_addr,
    input  logic                 alu_valid,
    output logic                 alu_ready,
    input  logic [3:0]           alu_addr,
    input  logic [DATA_BITS-1:0] alu_data,
    input  logic                 mem_valid,
    output logic                 mem_ready,
    input  logic [3:0]           mem_addr,
    input  logic [DATA_BITS-1:0] mem_data,
    output logic                 wr_enable,
    output logic [3:0]           wr_addr,
    output logic [DATA_BITS-1:0] wr_data,
    input  logic [3:0]           rd0_addr,
    input  logic                 rd0_enable,
    input  logic [3:0]           rd1_addr,
    input  logic                 rd1_enable,
    output logic [15:0]          busy,
    output logic                 hazard
`ifdef REGFILE_ARB_STATS_EN
    ,
    output logic [15:0]          conflict_count
`endif
);

    typedef enum logic {
        GRANT_ALU = 1'b0,
        GRANT_MEM = 1'b1
    } grant_t;

    grant_t      last_grant;
    logic        conflict;
    logic [15:0] busy_next;

    assign conflict = alu_valid & mem_valid;

    always_comb begin
        alu_ready = 1'b0;
        mem_ready = 1'b0;
        hazard    = 1'b0;
        if (!reset) begin
            alu_ready = alu_valid & (~mem_valid | (last_grant == GRANT_MEM));
            mem_ready = mem_valid & (~alu_valid | (last_grant == GRANT_ALU));
            hazard    = (rd0_enable & busy[rd0_addr]) | (rd1_enable & busy[rd1_addr]);
        end
    end

    // Clear before set so a new claim on the register being written wins.
    always_comb begin
        busy_next = busy;
        if (wr_enable) begin
            busy_next[wr_addr] = 1'b0;
        end
        if (claim_valid) begin
            busy_next[claim_addr] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_enable  <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            busy       <= '0;
            last_grant <= GRANT_MEM;
        end else begin
            busy      <= busy_next;
            wr_enable <= alu_ready | mem_ready;
            if (alu_ready) begin
                wr_addr <= alu_addr;
                wr_data <= alu_data;
            end else if (mem_ready) begin
                wr_addr <= mem_addr;
                wr_data <= mem_data;
            end
            if (conflict) begin
                last_grant <= alu_ready ? GRANT_ALU : GRANT_MEM;
            end
        end
    end

`ifdef REGFILE_ARB_STATS_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            conflict_count <= '0;
        end else if (conflict && (conflict_count != '1)) begin
            conflict_count <= conflict_count + 16'd1;
        end
    end
`endif

endmodule
